cbus_clint_bridge: RTL and testbench

Single-port CBus bridge between the `CBusArbiter` output and `RAMHelper2`. It carries a core-local interruptor (CLINT: `msip`, `mtimecmp`, `mtime`) and serves accesses to the CLINT window itself. All other transactions are forwarded unchanged to memory. It generates the `trint`/`swint` interrupt lines consumed by `core`. The memory model keeps driving `exint` independently.

---
 rtl/cbus_clint_bridge.sv | 177 +++++++++++++++++
 tb/tb_cbus_clint_bridge.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cbus_clint_bridge.sv
// rtl/cbus_clint_bridge.sv - CBus bridge carrying a CLINT (msip/mtimecmp/mtime) in front of memory
//
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   ireq   request from the arbiter
//   iresp  response to the arbiter
//   oreq   request to memory (mirrors ireq while forwarding)
//   oresp  response from memory
//   trint  timer interrupt, mtime >= mtimecmp (unsigned)
//   swint  software interrupt, msip[0]
// Parameter TICK_DIV (1..65535): mtime advances once every TICK_DIV cycles.
// Optional macro CLINT_MSIP_EN: implements msip; without it msip reads 0 and swint is 0.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [7:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;
endpackage

module cbus_clint_bridge
  import cbus_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireq,
  output cbus_resp_t iresp,
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp,
  output logic       trint,
  output logic       swint
);

  typedef enum logic [1:0] {IDLE, LOCAL, FWD} state_t;
  typedef enum logic [1:0] {SEL_MSIP, SEL_CMP, SEL_TIME, SEL_NONE} sel_t;

  state_t      state;
  sel_t        sel;
  logic        wr;
  logic [7:0]  beat;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [15:0] presc;
  logic        msip;

  logic        is_local;
  logic        last_beat;
  logic        commit;
  logic        tick;
  logic [63:0] rdata;
  logic [63:0] wdata;

  function automatic sel_t decode(input logic [12:0] off);
    case (off)
      13'h0000: return SEL_MSIP;
      13'h0800: return SEL_CMP;
      13'h17FF: return SEL_TIME;
      default:  return SEL_NONE;
    endcase
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_v,
                                        input logic [63:0] new_v,
                                        input logic [7:0]  strb);
    logic [63:0] r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  assign is_local  = (ireq.addr[63:16] == 48'h0000_0000_0200);
  assign last_beat = (state == LOCAL) && (beat == ireq.len);
  // Register updates land only on the final beat so every beat returns the pre-write value.
  assign commit    = last_beat && wr;
  assign tick      = (presc == 16'(TICK_DIV - 1));

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_MSIP: rdata = {63'b0, msip};
      SEL_CMP:  rdata = mtimecmp;
      SEL_TIME: rdata = mtime;
      default:  rdata = '0;
    endcase
  end

  // Merge onto the selected register image; unimplemented msip bits merge onto zeros and are dropped.
  assign wdata = merge(rdata, ireq.data, ireq.strobe);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel   <= SEL_NONE;
      wr    <= 1'b0;
      beat  <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (ireq.valid) begin
            sel   <= is_local ? decode(ireq.addr[15:3]) : SEL_NONE;
            wr    <= ireq.is_write;
            state <= is_local ? LOCAL : FWD;
          end
        end
        LOCAL: begin
          if (last_beat) state <= IDLE;
          else           beat  <= beat + 8'd1;
        end
        FWD: begin
          if (oresp.ready && oresp.last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime    <= '0;
      mtimecmp <= '1;
      presc    <= '0;
    end else begin
      presc <= tick ? 16'd0 : presc + 16'd1;
      // A software write to mtime wins over a coincident tick; that tick is lost.
      if (commit && sel == SEL_TIME) mtime <= wdata;
      else if (tick)                 mtime <= mtime + 64'd1;
      if (commit && sel == SEL_CMP)  mtimecmp <= wdata;
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk) begin
    if (reset)                          msip <= 1'b0;
    else if (commit && sel == SEL_MSIP) msip <= wdata[0];
  end
`else
  assign msip = 1'b0;
`endif

  always_comb begin
    iresp = '0;
    oreq  = '0;
    case (state)
      LOCAL: begin
        iresp.ready = 1'b1;
        iresp.last  = last_beat;
        iresp.data  = rdata;
      end
      FWD: begin
        oreq  = ireq;
        iresp = oresp;
      end
      default: ;
    endcase
  end

  assign trint = (mtime >= mtimecmp);
  assign swint = msip;

endmodule

// File: tb/tb_cbus_clint_bridge.sv
// tb/tb_cbus_clint_bridge.sv - self-checking bench for cbus_clint_bridge
module tb_cbus_clint_bridge;
  import cbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireq;
  cbus_resp_t iresp;
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic       trint;
  logic       swint;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cbus_clint_bridge #(.TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .ireq(ireq), .iresp(iresp),
    .oreq(oreq), .oresp(oresp), .trint(trint), .swint(swint)
  );

  localparam logic [47:0] WIN = 48'h0000_0000_0200;

  // Reference model: mtime is a linear function of elapsed cycles since its last anchor.
  logic [63:0] mt_base;
  int          mt_cyc;
  logic [63:0] cmp_m;
  logic        msip_m;

  function automatic logic [63:0] mtime_at(input int c);
    return mt_base + 64'(c - mt_cyc);
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a, input int c);
    if (a[63:16] != WIN) return 64'h0;
    if (a[15:3] == 13'h0000) return {63'b0, msip_m};
    if (a[15:3] == 13'h0800) return cmp_m;
    if (a[15:3] == 13'h17FF) return mtime_at(c);
    return 64'h0;
  endfunction

  task automatic model_reset(input int c);
    mt_base = 64'h0;
    mt_cyc  = c;
    cmp_m   = '1;
    msip_m  = 1'b0;
  endtask

  // c is the cycle count right after the committing edge.
  task automatic model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s, input int c);
    logic [63:0] v;
    v = model_read(a, c - 1);
    for (int i = 0; i < 8; i++) if (s[i]) v[i*8 +: 8] = d[i*8 +: 8];
    if (a[63:16] == WIN) begin
      if (a[15:3] == 13'h0800) cmp_m = v;
      if (a[15:3] == 13'h17FF) begin mt_base = v; mt_cyc = c; end
`ifdef CLINT_MSIP_EN
      if (a[15:3] == 13'h0000) msip_m = v[0];
`endif
    end
  endtask

  // Local transaction driver: records each response beat and the model's expectation for it.
  logic [63:0] bd[8];
  logic [63:0] be[8];
  logic        bl[8];
  int          bc[8];
  int          nb;
  int          t0;

  task automatic do_local(input bit w, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [7:0] l);
    bit done;
    nb = 0;
    done = 0;
    @(posedge clk); #1;
    t0 = cyc;
    ireq = '0;
    ireq.valid = 1'b1; ireq.is_write = w; ireq.size = 3'd3;
    ireq.addr = a; ireq.data = d; ireq.strobe = s; ireq.len = l;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (iresp.ready && nb < 8) begin
        bd[nb] = iresp.data;
        bl[nb] = iresp.last;
        bc[nb] = cyc;
        be[nb] = model_read(a, cyc);
        done   = iresp.last;
        nb++;
      end
    end
    @(posedge clk); #1;
    ireq = '0;
    if (w && done) model_write(a, d, s, cyc);
  endtask

  task automatic test_reset();
    reset = 1'b1; ireq = '0; oresp = '0;
    repeat (3) @(posedge clk);
    #1;
    model_reset(cyc);
    reset = 1'b0;
    @(negedge clk);
    tests++; if (iresp !== '0) begin fails++; $display("FAIL reset_iresp got=%h exp=0", iresp); end
    tests++; if (oreq  !== '0) begin fails++; $display("FAIL reset_oreq got=%h exp=0", oreq); end
    tests++; if (trint !== 1'b0) begin fails++; $display("FAIL reset_trint got=%b exp=0", trint); end
    tests++; if (swint !== 1'b0) begin fails++; $display("FAIL reset_swint got=%b exp=0", swint); end
  endtask

  task automatic test_mtime_read();
    repeat (10) @(posedge clk);
    do_local(1'b0, {WIN, 16'hBFF8}, 64'h0, 8'h0, 8'd0);
    tests++; if (nb !== 1) begin fails++; $display("FAIL mtime_read_beats got=%0d exp=1", nb); end
    tests++; if (nb > 0 && bc[0] - t0 !== 1) begin fails++; $display("FAIL local_latency got=%0d exp=1", bc[0] - t0); end
    tests++; if (nb > 0 && bl[0] !== 1'b1) begin fails++; $display("FAIL mtime_read_last got=%b exp=1", bl[0]); end
    tests++; if (nb > 0 && bd[0] !== be[0]) begin fails++; $display("FAIL mtime_read_data got=%h exp=%h", bd[0], be[0]); end
    @(negedge clk);
    tests++; if (trint !== 1'b0) begin fails++; $display("FAIL mtime_read_trint got=%b exp=0", trint); end
  endtask

  task automatic test_trint();
    logic [63:0] target;
    bit          seen;
    logic        exp;
    target = mtime_at(cyc) + 64'd12;
    seen = 0;
    do_local(1'b1, {WIN, 16'h4000}, target, 8'hFF, 8'd0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      exp = (mtime_at(cyc) >= cmp_m);
      tests++; if (trint !== exp) begin fails++; $display("FAIL trint_track cyc=%0d got=%b exp=%b", cyc, trint, exp); end
      if (trint === 1'b1 && !seen) begin
        seen = 1;
        tests++; if (mtime_at(cyc) !== target) begin fails++; $display("FAIL trint_rise_cycle mtime=%0d exp=%0d", mtime_at(cyc), target); end
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL trint_rise got=0 exp=1"); end
    do_local(1'b1, {WIN, 16'h4000}, '1, 8'hFF, 8'd0);
    @(negedge clk);
    tests++; if (trint !== 1'b0) begin fails++; $display("FAIL trint_drop got=%b exp=0", trint); end
  endtask

  task automatic test_msip();
    logic exp_sw;
`ifdef CLINT_MSIP_EN
    exp_sw = 1'b1;
`else
    exp_sw = 1'b0;
`endif
    do_local(1'b1, {WIN, 16'h0000}, 64'h1, 8'hFF, 8'd0);
    @(negedge clk);
    tests++; if (swint !== exp_sw) begin fails++; $display("FAIL msip_swint got=%b exp=%b", swint, exp_sw); end
    do_local(1'b0, {WIN, 16'h0000}, 64'h0, 8'h0, 8'd0);
    tests++; if (nb < 1 || bd[0] !== {63'b0, exp_sw}) begin fails++; $display("FAIL msip_read got=%h exp=%h", bd[0], {63'b0, exp_sw}); end
  endtask

  task automatic test_mtime_strobe();
    do_local(1'b1, {WIN, 16'hBFF8}, 64'hAAAA_BBBB_1234_5678, 8'h0F, 8'd0);
    do_local(1'b0, {WIN, 16'hBFF8}, 64'h0, 8'h0, 8'd0);
    tests++; if (nb < 1 || bd[0] !== be[0]) begin fails++; $display("FAIL mtime_strobe_data got=%h exp=%h", bd[0], be[0]); end
    tests++; if (nb < 1 || bd[0][63:32] !== 32'h0) begin fails++; $display("FAIL mtime_strobe_upper got=%h exp=0", bd[0][63:32]); end
    tests++; if (nb < 1 || bd[0] !== 64'h1234_5678 + 64'(bc[0] - mt_cyc)) begin
      fails++; $display("FAIL mtime_strobe_tick got=%h exp=%h", bd[0], 64'h1234_5678 + 64'(bc[0] - mt_cyc));
    end
  endtask

  task automatic test_fwd();
    cbus_req_t  r;
    cbus_resp_t er;
    int         lat;
    for (int k = 0; k < 4; k++) begin
      r = '0;
      r.valid = 1'b1; r.size = 3'd3;
      if (k == 0) begin
        r.addr = 64'h8000_0000; r.len = 8'd3;
      end else begin
        r.addr     = 64'h8000_0000 + (64'($urandom_range(0, 16'hFFFF)) << 3);
        r.is_write = 1'($urandom_range(0, 1));
        r.data     = {$urandom, $urandom};
        r.strobe   = 8'($urandom);
        r.len      = 8'($urandom_range(0, 3));
      end
      lat = $urandom_range(0, 3);
      @(posedge clk); #1;
      ireq = r; oresp = '0;
      @(negedge clk);
      tests++; if (oreq.valid !== 1'b0) begin fails++; $display("FAIL fwd_accept_cycle k=%0d got=%b exp=0", k, oreq.valid); end
      @(posedge clk); #1;
      @(negedge clk);
      tests++; if (oreq !== r) begin fails++; $display("FAIL fwd_oreq_t1 k=%0d got=%h exp=%h", k, oreq, r); end
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        tests++; if (iresp.ready !== 1'b0) begin fails++; $display("FAIL fwd_wait k=%0d got=%b exp=0", k, iresp.ready); end
      end
      for (int b = 0; b <= int'(r.len); b++) begin
        @(posedge clk); #1;
        er.ready = 1'b1; er.last = (b == int'(r.len)); er.data = {$urandom, $urandom};
        oresp = er;
        @(negedge clk);
        tests++; if (iresp !== er) begin fails++; $display("FAIL fwd_beat k=%0d b=%0d got=%h exp=%h", k, b, iresp, er); end
        tests++; if (oreq !== r) begin fails++; $display("FAIL fwd_oreq k=%0d b=%0d got=%h exp=%h", k, b, oreq, r); end
      end
      @(posedge clk); #1;
      oresp = '0; ireq = '0;
      @(negedge clk);
      tests++; if (oreq.valid !== 1'b0) begin fails++; $display("FAIL fwd_done_oreq k=%0d got=%b exp=0", k, oreq.valid); end
    end
  endtask

  task automatic test_local_burst();
    do_local(1'b0, {WIN, 16'h4000}, 64'h0, 8'h0, 8'd1);
    tests++; if (nb !== 2) begin fails++; $display("FAIL burst_beats got=%0d exp=2", nb); end
    if (nb == 2) begin
      tests++; if (bl[0] !== 1'b0 || bl[1] !== 1'b1) begin fails++; $display("FAIL burst_last got=%b%b exp=01", bl[0], bl[1]); end
      tests++; if (bd[0] !== cmp_m || bd[1] !== cmp_m) begin fails++; $display("FAIL burst_data got=%h,%h exp=%h", bd[0], bd[1], cmp_m); end
    end
  endtask

  task automatic test_random_local();
    logic [15:0] off;
    logic [63:0] a;
    logic [7:0]  l;
    logic        exp;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 3))
        0:       off = 16'h0000;
        1:       off = 16'h4000;
        2:       off = 16'hBFF8;
        default: off = 16'($urandom_range(1, 16'h7FF)) << 3;
      endcase
      a = {WIN, off};
      l = 8'($urandom_range(0, 2));
      do_local(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), l);
      tests++; if (nb !== int'(l) + 1) begin fails++; $display("FAIL rnd_beats k=%0d got=%0d exp=%0d", k, nb, int'(l) + 1); end
      for (int i = 0; i < nb; i++) begin
        tests++; if (bd[i] !== be[i]) begin fails++; $display("FAIL rnd_data k=%0d beat=%0d got=%h exp=%h", k, i, bd[i], be[i]); end
      end
      @(negedge clk);
      exp = (mtime_at(cyc) >= cmp_m);
      tests++; if (trint !== exp) begin fails++; $display("FAIL rnd_trint k=%0d got=%b exp=%b", k, trint, exp); end
      tests++; if (swint !== msip_m) begin fails++; $display("FAIL rnd_swint k=%0d got=%b exp=%b", k, swint, msip_m); end
    end
  endtask

  task automatic test_reset_mid();
    cbus_req_t r;
    r = '0;
    r.valid = 1'b1; r.size = 3'd3; r.addr = 64'h8000_0000; r.len = 8'd3;
    do_local(1'b1, {WIN, 16'h4000}, 64'h5, 8'hFF, 8'd0);
    @(posedge clk); #1;
    ireq = r;
    @(posedge clk); #1;
    oresp.ready = 1'b1; oresp.last = 1'b0; oresp.data = 64'hDEAD_BEEF;
    reset = 1'b1;
    @(posedge clk); #1;
    oresp = '0;
    @(negedge clk);
    tests++; if (oreq.valid !== 1'b0) begin fails++; $display("FAIL rst_mid_oreq got=%b exp=0", oreq.valid); end
    tests++; if (iresp !== '0) begin fails++; $display("FAIL rst_mid_iresp got=%h exp=0", iresp); end
    tests++; if (trint !== 1'b0) begin fails++; $display("FAIL rst_mid_trint got=%b exp=0", trint); end
    @(posedge clk); #1;
    model_reset(cyc);
    reset = 1'b0;
    ireq = '0;
    do_local(1'b0, {WIN, 16'h4000}, 64'h0, 8'h0, 8'd0);
    tests++; if (nb < 1 || bd[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin fails++; $display("FAIL rst_mid_cmp got=%h exp=ffffffffffffffff", bd[0]); end
    do_local(1'b0, {WIN, 16'hBFF8}, 64'h0, 8'h0, 8'd0);
    tests++; if (nb < 1 || bd[0] !== be[0]) begin fails++; $display("FAIL rst_mid_mtime got=%h exp=%h", bd[0], be[0]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mtime_read();
    test_trint();
    test_msip();
    test_mtime_strobe();
    test_fwd();
    test_local_burst();
    test_random_local();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
